// File: rtl/alarm_system_pkg.sv
// Package: alarm_system_pkg
// Shared register map and CTRL bit layout for the alarm system LED/buzzer output port.
// Contents:
//   ADDR_*     Avalon register addresses (DATA, CTRL, HALF, PULSES)
//   CTRL_*     bit positions inside the CTRL register
//   ctrl_t     the three CPU-writable CTRL bits
//   ctrl_word  builds the 32-bit CTRL read value from the stored and status bits
package alarm_system_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_HALF   = 2'd2;
    localparam logic [1:0] ADDR_PULSES = 2'd3;

    localparam int unsigned CTRL_BLINK_EN = 0;
    localparam int unsigned CTRL_ONESHOT  = 1;
    localparam int unsigned CTRL_IRQ_EN   = 2;
    localparam int unsigned CTRL_DONE     = 3;
    localparam int unsigned CTRL_PHASE    = 4;

    // Busy flag position in the PULSES read value.
    localparam int unsigned PULSES_BUSY = 31;

    typedef struct packed {
        logic irq_en;
        logic oneshot;
        logic blink_en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_word(input ctrl_t c, input logic done,
                                              input logic phase);
        logic [31:0] w;
        w                = '0;
        w[CTRL_BLINK_EN] = c.blink_en;
        w[CTRL_ONESHOT]  = c.oneshot;
        w[CTRL_IRQ_EN]   = c.irq_en;
        w[CTRL_DONE]     = done;
        w[CTRL_PHASE]    = phase;
        return w;
    endfunction

endpackage

// File: rtl/alarm_system_led_out_if.sv
// Interface: alarm_system_led_out_if
// Avalon-MM slave bus between the Nios II data master and the LED/buzzer output port.
// Signals:
//   address    2   register select
//   chipselect 1   slave select
//   write_n    1   active-low write strobe, qualified by chipselect
//   writedata  32  write data
//   readdata   32  registered read data from the slave
// Modports: master (CPU side), slave (peripheral side).
interface alarm_system_led_out_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/alarm_system_blink_timer.sv
// Module: alarm_system_blink_timer
// Half-period blink timer with one-shot pulse counting and a sticky completion flag.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   enable        current (registered) blink_en
//   oneshot       current (registered) one-shot mode bit
//   half          half-period in cycles, 0 behaves as 1
//   ctrl_load     CTRL is written this cycle
//   enable_new    blink_en value that CTRL write stores
//   done_set      one-shot start requested with no pulses left
//   pulses_load   PULSES is written this cycle
//   pulses_new    value loaded into the pulse counter
//   phase         current blink phase (1 = pattern shown)
//   done          sticky completion flag
//   pulses        remaining one-shot pulses
//   complete      final pulse ends this cycle; owner clears blink_en
module alarm_system_blink_timer #(
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned PULSE_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               oneshot,
    input  logic [CNT_W-1:0]   half,
    input  logic               ctrl_load,
    input  logic               enable_new,
    input  logic               done_set,
    input  logic               pulses_load,
    input  logic [PULSE_W-1:0] pulses_new,
    output logic               phase,
    output logic               done,
    output logic [PULSE_W-1:0] pulses,
    output logic               complete
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;
    logic             toggle;
    logic             pulse_end;
    logic             last_pulse;

    // Compare with >= so that shrinking HALF mid-count toggles on the next cycle.
    assign limit      = (half == '0) ? '0 : half - 1'b1;
    assign toggle     = enable & (cnt >= limit);
    assign pulse_end  = toggle & phase & oneshot;
    // <= 1 rather than == 1 so a run left with zero pulses also terminates.
    assign last_pulse = pulse_end & (pulses <= PULSE_W'(1));
    // A PULSES write in the same cycle restarts the count and cancels completion.
    assign complete   = last_pulse & ~pulses_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            phase  <= 1'b0;
            done   <= 1'b0;
            pulses <= '0;
        end else begin
            // Enable edges written by the CPU restart the half-period; a start shows the
            // pattern first.
            if (ctrl_load && (enable_new != enable)) begin
                cnt   <= '0;
                phase <= enable_new;
            end else if (toggle) begin
                // The last pulse always ends on a 1->0 toggle, so phase lands at 0.
                cnt   <= '0;
                phase <= ~phase;
            end else if (enable) begin
                cnt <= cnt + 1'b1;
            end

            if (pulses_load) begin
                pulses <= pulses_new;
                done   <= 1'b0;
            end else begin
                if (pulse_end) begin
                    pulses <= last_pulse ? '0 : pulses - 1'b1;
                end
                if (last_pulse || done_set) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alarm_system_led_out.sv
// Module: alarm_system_led_out
// Avalon-MM output port driving the alarm LEDs/buzzer: a CPU-written pattern shown steady or
// blinking, with a one-shot mode that stops after N pulses and raises a maskable IRQ.
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   bus       Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   irq       done & irq_en
//   out_port  registered pattern to the pins
// Registers: 0 DATA, 1 CTRL {phase, done, irq_en, oneshot, blink_en}, 2 HALF,
//            3 PULSES (write loads count and clears done; read {busy, remaining}).
module alarm_system_led_out
    import alarm_system_pkg::*;
#(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       CNT_W       = 24,
    parameter int unsigned       PULSE_W     = 16,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alarm_system_led_out_if.slave bus,
    output logic                 irq,
    output logic [DATA_W-1:0]    out_port
);

    logic wr_en;
    logic data_wr;
    logic ctrl_wr;
    logic half_wr;
    logic pulses_wr;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign data_wr   = wr_en & (bus.address == ADDR_DATA);
    assign ctrl_wr   = wr_en & (bus.address == ADDR_CTRL);
    assign half_wr   = wr_en & (bus.address == ADDR_HALF);
    assign pulses_wr = wr_en & (bus.address == ADDR_PULSES);

    logic [DATA_W-1:0]  data_q;
    ctrl_t              ctrl_q;
    logic [CNT_W-1:0]   half_q;
    logic [31:0]        readdata_q;
    logic [31:0]        rd_mux;
    logic               phase;
    logic               done;
    logic               complete;
    logic [PULSE_W-1:0] pulses;
    logic               start_empty;
    logic               enable_new;
    logic               unused_wdata;

    // Starting a one-shot with nothing to count never blinks: it finishes immediately.
    assign start_empty = ctrl_wr & bus.writedata[CTRL_BLINK_EN] & bus.writedata[CTRL_ONESHOT]
                       & (pulses == '0);
    assign enable_new  = bus.writedata[CTRL_BLINK_EN] & ~start_empty;

    assign unused_wdata = ^bus.writedata;

    alarm_system_blink_timer #(
        .CNT_W   (CNT_W),
        .PULSE_W (PULSE_W)
    ) u_blink_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (ctrl_q.blink_en),
        .oneshot     (ctrl_q.oneshot),
        .half        (half_q),
        .ctrl_load   (ctrl_wr),
        .enable_new  (enable_new),
        .done_set    (start_empty),
        .pulses_load (pulses_wr),
        .pulses_new  (bus.writedata[PULSE_W-1:0]),
        .phase       (phase),
        .done        (done),
        .pulses      (pulses),
        .complete    (complete)
    );

    // Read mux is not qualified by chipselect; readdata follows address every cycle.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:   rd_mux[DATA_W-1:0] = data_q;
            ADDR_CTRL:   rd_mux = ctrl_word(ctrl_q, done, phase);
            ADDR_HALF:   rd_mux[CNT_W-1:0] = half_q;
            ADDR_PULSES: begin
                rd_mux[PULSES_BUSY]   = ctrl_q.blink_en;
                rd_mux[PULSE_W-1:0]   = pulses;
            end
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            ctrl_q     <= '0;
            half_q     <= '0;
            readdata_q <= '0;
            out_port   <= RESET_VALUE;
        end else begin
            if (data_wr) begin
                data_q <= bus.writedata[DATA_W-1:0];
            end

            // A CPU write to CTRL takes priority over the one-shot auto-stop.
            if (ctrl_wr) begin
                ctrl_q.blink_en <= enable_new;
                ctrl_q.oneshot  <= bus.writedata[CTRL_ONESHOT];
                ctrl_q.irq_en   <= bus.writedata[CTRL_IRQ_EN];
            end else if (complete) begin
                ctrl_q.blink_en <= 1'b0;
            end

            if (half_wr) begin
                half_q <= bus.writedata[CNT_W-1:0];
            end

            readdata_q <= rd_mux;
            out_port   <= ctrl_q.blink_en ? (phase ? data_q : '0) : data_q;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = done & ctrl_q.irq_en;

endmodule
